icache_fetch_unit: RTL

Direct-mapped instruction cache and fetch-side miss controller that produces the instruction word and the `hit` qualifier consumed by the IF/ID pipeline register. On a lookup hit it returns the addressed word combinationally in the same cycle. On a miss it refills a whole block from instruction memory through a ready-qualified read port, holding `hit` low so IF/ID and the PC stall. It sits between the PC/adder logic and IF/ID on one side, and instruction memory on the other.

---
 rtl/icache_fetch_unit.sv | 130 +++++++++++++
 1 files changed

// File: rtl/icache_fetch_unit.sv
// Direct-mapped instruction cache with a blocking, in-order block refill.
// Hits return the word combinationally; misses stall fetch until refilled.
module icache_fetch_unit #(
    parameter int INDEX_BITS  = 4,
    parameter int OFFSET_BITS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        flush,
    output logic [31:0] instruction,
    output logic        hit,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int WORDS    = 1 << OFFSET_BITS;
    localparam int TAG_LSB  = INDEX_BITS + OFFSET_BITS + 2;
    localparam int TAG_BITS = 32 - TAG_LSB;
    localparam int BLK_BITS = 30 - OFFSET_BITS;
    localparam logic [OFFSET_BITS-1:0] LAST_BEAT = '1;

    typedef enum logic {
        LOOKUP,
        REFILL
    } state_t;

    state_t state_q, state_d;
    logic [OFFSET_BITS-1:0] beat_q, beat_d;
    logic [BLK_BITS-1:0]    blk_q, blk_d;
    logic [LINES-1:0]       valid_q, valid_d;

    logic [31:0]         data_q [LINES*WORDS];
    logic [TAG_BITS-1:0] tag_q  [LINES];

    logic [OFFSET_BITS-1:0] pc_off;
    logic [INDEX_BITS-1:0]  pc_idx;
    logic [TAG_BITS-1:0]    pc_tag;
    logic [INDEX_BITS-1:0]  line;
    logic [TAG_BITS-1:0]    blk_tag;
    logic                   lookup_hit;
    logic                   wr_data;
    logic                   wr_tag;
    logic                   unused_pc;

    assign pc_off     = pc[OFFSET_BITS+1:2];
    assign pc_idx     = pc[TAG_LSB-1:OFFSET_BITS+2];
    assign pc_tag     = pc[31:TAG_LSB];
    assign unused_pc  = ^pc[1:0];
    assign line       = blk_q[INDEX_BITS-1:0];
    assign blk_tag    = blk_q[BLK_BITS-1:INDEX_BITS];
    assign lookup_hit = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);

    // Next state, array write strobes and fetch/memory outputs.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        blk_d       = blk_q;
        valid_d     = valid_q;
        hit         = 1'b0;
        instruction = 32'h0;
        mem_read    = 1'b0;
        mem_addr    = 32'h0;
        wr_data     = 1'b0;
        wr_tag      = 1'b0;
        unique case (state_q)
            LOOKUP: begin
                if (flush) begin
                    valid_d = '0;
                end else if (lookup_hit) begin
                    hit         = 1'b1;
                    instruction = data_q[{pc_idx, pc_off}];
                end else begin
                    blk_d           = pc[31:OFFSET_BITS+2];
                    beat_d          = '0;
                    valid_d[pc_idx] = 1'b0;
                    state_d         = REFILL;
                end
            end
            REFILL: begin
                mem_read = 1'b1;
                mem_addr = {blk_q, beat_q, 2'b00};
                if (flush) begin
                    valid_d = '0;
                    beat_d  = '0;
                    state_d = LOOKUP;
                end else if (mem_ready) begin
                    wr_data = 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        wr_tag        = 1'b1;
                        valid_d[line] = 1'b1;
                        beat_d        = '0;
                        state_d       = LOOKUP;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
        endcase
    end

    // Control state; reset drops valid bits and any refill in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOOKUP;
            beat_q  <= '0;
            blk_q   <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            blk_q   <= blk_d;
            valid_q <= valid_d;
        end
    end

    // Data and tag storage; contents survive reset, valid bits gate use.
    always_ff @(posedge clk) begin
        if (!rst && wr_data) begin
            data_q[{line, beat_q}] <= mem_rdata;
        end
        if (!rst && wr_tag) begin
            tag_q[line] <= blk_tag;
        end
    end

endmodule
